// File: rtl/rtc_pkg.sv
// Shared encodings for the RTC command responder: register map, init table,
// command/state/phase enums and the access record passed to the bus engine.
package rtc_pkg;

  localparam logic [7:0] REG_CTRL      = 8'h02;
  localparam logic [7:0] CTRL_HOLD     = 8'h10;
  localparam logic [7:0] REG_STATUS    = 8'h10;
  localparam logic [7:0] REG_TIME_BASE = 8'h20;
  localparam logic [7:0] REG_XFER      = 8'hF0;
  localparam logic [7:0] XFER_KEY      = 8'hF0;
  localparam logic [7:0] REG_COMMIT    = 8'hF1;
  localparam logic [7:0] COMMIT_KEY    = 8'hF1;
  localparam int         INIT_LEN      = 3;

  typedef struct packed {
    logic       rw;    // 1 = read
    logic [7:0] addr;
    logic [7:0] data;
  } access_t;

  typedef enum logic [1:0] {CMD_NONE, CMD_INIT, CMD_READ, CMD_WRITE} cmd_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_WAIT_REL} state_e;
  typedef enum logic [1:0] {PH_ADDR, PH_AGAP, PH_DATA, PH_DGAP} phase_e;

  // Init: raise the hold bit, drop it, then clear the status register.
  function automatic access_t init_access(input logic [1:0] i);
    case (i)
      2'd0:    return '{rw: 1'b0, addr: REG_CTRL,   data: CTRL_HOLD};
      2'd1:    return '{rw: 1'b0, addr: REG_CTRL,   data: 8'h00};
      default: return '{rw: 1'b0, addr: REG_STATUS, data: 8'h00};
    endcase
  endfunction

endpackage

// File: rtl/rtc_bus_cycle.sv
// Single RTC bus access: ADDR phase then DATA phase, each strobe pulse followed by a gap.
// A new start is accepted in the last gap cycle so accesses can run back-to-back.
module rtc_bus_cycle
  import rtc_pkg::*;
#(
  parameter int T_PULSE = 4,
  parameter int T_GAP   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] ad_i,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       cs_n,
  output logic       ad_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic [7:0] ad_o,
  output logic       ad_oe
);

  localparam int TMAX = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
  localparam int CW   = $clog2(TMAX + 1);

  phase_e        phase;
  logic [CW-1:0] cnt;
  logic          rw_q;
  logic [7:0]    data_q;
  logic          last;

  always_comb begin
    last = 1'b0;
    if (phase == PH_ADDR || phase == PH_DATA) last = (cnt == CW'(T_PULSE - 1));
    else                                      last = (cnt == CW'(T_GAP - 1));
  end

  assign done = busy && (phase == PH_DGAP) && last;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      phase  <= PH_ADDR;
      cnt    <= '0;
      rw_q   <= 1'b0;
      data_q <= '0;
      rdata  <= '0;
      cs_n   <= 1'b1;
      ad_n   <= 1'b1;
      rd_n   <= 1'b1;
      wr_n   <= 1'b1;
      ad_o   <= '0;
      ad_oe  <= 1'b0;
    end else if (start && (!busy || done)) begin
      busy   <= 1'b1;
      phase  <= PH_ADDR;
      cnt    <= '0;
      rw_q   <= rw;
      data_q <= wdata;
      cs_n   <= 1'b0;
      ad_n   <= 1'b0;
      rd_n   <= 1'b1;
      wr_n   <= 1'b0;
      ad_o   <= addr;
      ad_oe  <= 1'b1;
    end else if (busy) begin
      if (!last) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
        case (phase)
          PH_ADDR: begin
            phase <= PH_AGAP;
            wr_n  <= 1'b1;
            ad_oe <= 1'b0;
          end
          PH_AGAP: begin
            phase <= PH_DATA;
            ad_n  <= 1'b1;
            if (rw_q) rd_n <= 1'b0;
            else begin
              wr_n  <= 1'b0;
              ad_oe <= 1'b1;
              ad_o  <= data_q;
            end
          end
          PH_DATA: begin
            phase <= PH_DGAP;
            cs_n  <= 1'b1;
            rd_n  <= 1'b1;
            wr_n  <= 1'b1;
            ad_oe <= 1'b0;
            if (rw_q) rdata <= ad_i;  // last rd_n-low cycle
          end
          default: begin
            busy  <= 1'b0;
            phase <= PH_ADDR;
            ad_o  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/rtc_cmd_responder.sv
// Sequencer turning controller level commands into RTC register-access sequences,
// pulsing the matching done flag and holding the last time read back.
module rtc_cmd_responder
  import rtc_pkg::*;
#(
  parameter int T_PULSE     = 4,
  parameter int T_GAP       = 2,
  parameter int N_TIME_REGS = 6
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        iniciar,
  input  logic        whileT,
  input  logic        CrontUs,
  input  logic [47:0] user_time,
  output logic        finint,
  output logic        finwt,
  output logic        finct,
  output logic [47:0] rtc_time,
  output logic        rtc_cs_n,
  output logic        rtc_ad_n,
  output logic        rtc_rd_n,
  output logic        rtc_wr_n,
  output logic [7:0]  rtc_ad_o,
  output logic        rtc_ad_oe,
  input  logic [7:0]  rtc_ad_i
);

  state_e      state;
  cmd_e        cmd;
  logic [3:0]  idx;
  logic [3:0]  n_acc;
  logic [47:0] ut_q;
  logic [47:0] rd_buf;
  logic [47:0] rd_buf_nxt;
  access_t     acc;
  logic        start;
  logic        busy;
  logic        done;
  logic [7:0]  rdata;

  // idx counts accesses already launched; the one finishing on done is idx-1.
  assign n_acc = (cmd == CMD_INIT) ? 4'(INIT_LEN) : 4'(N_TIME_REGS + 1);
  assign start = (state == S_RUN) && ((idx == 4'd0) ? !busy : (done && idx < n_acc));

  always_comb begin
    acc = '0;
    case (cmd)
      CMD_INIT: acc = init_access(idx[1:0]);
      CMD_READ: begin
        if (idx == 4'd0) acc = '{rw: 1'b0, addr: REG_XFER, data: XFER_KEY};
        else             acc = '{rw: 1'b1, addr: REG_TIME_BASE + 8'(idx), data: 8'h00};
      end
      CMD_WRITE: begin
        if (idx < 4'(N_TIME_REGS))
          acc = '{rw: 1'b0, addr: REG_TIME_BASE + 8'(idx) + 8'd1, data: ut_q[8*int'(idx) +: 8]};
        else
          acc = '{rw: 1'b0, addr: REG_COMMIT, data: COMMIT_KEY};
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_buf_nxt = rd_buf;
    if (cmd == CMD_READ && done && idx >= 4'd2)
      rd_buf_nxt[8*(int'(idx) - 2) +: 8] = rdata;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= S_IDLE;
      cmd      <= CMD_NONE;
      idx      <= '0;
      ut_q     <= '0;
      rd_buf   <= '0;
      rtc_time <= '0;
      finint   <= 1'b0;
      finwt    <= 1'b0;
      finct    <= 1'b0;
    end else begin
      finint <= 1'b0;
      finwt  <= 1'b0;
      finct  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (iniciar || CrontUs || whileT) begin
            cmd    <= iniciar ? CMD_INIT : (CrontUs ? CMD_WRITE : CMD_READ);
            ut_q   <= user_time;
            idx    <= '0;
            rd_buf <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          rd_buf <= rd_buf_nxt;
          if (start) idx <= idx + 4'd1;
          if (done && idx == n_acc) begin
            state  <= S_DONE;
            finint <= (cmd == CMD_INIT);
            finwt  <= (cmd == CMD_READ);
            finct  <= (cmd == CMD_WRITE);
            // all time bytes land together, in step with the done pulse
            if (cmd == CMD_READ) rtc_time <= rd_buf_nxt;
          end
        end
        S_DONE:     state <= S_WAIT_REL;
        S_WAIT_REL: if (!(iniciar || CrontUs || whileT)) state <= S_IDLE;
        default:    state <= S_IDLE;
      endcase
    end
  end

  rtc_bus_cycle #(.T_PULSE(T_PULSE), .T_GAP(T_GAP)) u_bus (
    .clk   (CLK),
    .reset (reset),
    .start (start),
    .rw    (acc.rw),
    .addr  (acc.addr),
    .wdata (acc.data),
    .ad_i  (rtc_ad_i),
    .busy  (busy),
    .done  (done),
    .rdata (rdata),
    .cs_n  (rtc_cs_n),
    .ad_n  (rtc_ad_n),
    .rd_n  (rtc_rd_n),
    .wr_n  (rtc_wr_n),
    .ad_o  (rtc_ad_o),
    .ad_oe (rtc_ad_oe)
  );

endmodule

// File: tb/tb_rtc_cmd_responder.sv
// Bench for rtc_cmd_responder: RTC slave/bus monitor, directed vector table,
// reset-abort sequence and randomized commands against a sequence-level model.
module tb_rtc_cmd_responder;
  localparam int TP  = 4;
  localparam int TG  = 2;
  localparam int N   = 6;
  localparam int ACC = 2 * (TP + TG);

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        iniciar = 1'b0, whileT = 1'b0, CrontUs = 1'b0;
  logic [47:0] user_time = '0;
  logic        finint, finwt, finct;
  logic [47:0] rtc_time;
  logic        rtc_cs_n, rtc_ad_n, rtc_rd_n, rtc_wr_n, rtc_ad_oe;
  logic [7:0]  rtc_ad_o, rtc_ad_i;

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // RTC chip model: register file answering reads, updated by writes
  logic [7:0] mem [256];
  logic [7:0] lat_addr = 8'h00;
  assign rtc_ad_i = !rtc_rd_n ? mem[lat_addr] : 8'h00;

  rtc_cmd_responder #(.T_PULSE(TP), .T_GAP(TG), .N_TIME_REGS(N)) dut (
    .CLK(CLK), .reset(reset), .iniciar(iniciar), .whileT(whileT), .CrontUs(CrontUs),
    .user_time(user_time), .finint(finint), .finwt(finwt), .finct(finct),
    .rtc_time(rtc_time), .rtc_cs_n(rtc_cs_n), .rtc_ad_n(rtc_ad_n), .rtc_rd_n(rtc_rd_n),
    .rtc_wr_n(rtc_wr_n), .rtc_ad_o(rtc_ad_o), .rtc_ad_oe(rtc_ad_oe), .rtc_ad_i(rtc_ad_i)
  );

  typedef struct {logic rw; logic [7:0] addr; logic [7:0] data; int cs_lo; int st_lo;} mon_t;
  typedef struct {logic rw; logic [7:0] addr; logic [7:0] data;} exp_t;
  typedef struct {
    logic [2:0] mask;      // {CrontUs, whileT, iniciar}
    logic [47:0] ut;
    logic        preload;
    logic [47:0] pre;
    int          drop_at;
    int          kind;     // 1 init, 2 read, 3 write
    logic [47:0] exp_rtc;
  } vec_t;

  mon_t        acc_q[$];
  exp_t        exp_q[$];
  mon_t        cur;
  int          first_fall = -1;
  logic        prev_cs = 1'b1;
  logic        in_acc = 1'b0;
  logic [47:0] exp_time = '0;
  int          n_cmp = 0;
  int          n_err = 0;

  // Bus monitor: one record per cs_n-low window
  initial forever begin
    @(negedge CLK);
    if (!rtc_cs_n && prev_cs) begin
      in_acc = 1'b1;
      cur = '{1'b0, 8'h00, 8'h00, 0, 0};
      if (first_fall < 0) first_fall = cyc;
    end
    if (!rtc_cs_n) cur.cs_lo++;
    if (!rtc_rd_n || !rtc_wr_n) cur.st_lo++;
    if (!rtc_cs_n && !rtc_ad_n && !rtc_wr_n) begin
      cur.addr = rtc_ad_o;
      lat_addr = rtc_ad_o;
    end
    if (!rtc_cs_n && rtc_ad_n && !rtc_wr_n && rtc_ad_oe) cur.data = rtc_ad_o;
    if (!rtc_cs_n && rtc_ad_n && !rtc_rd_n) cur.rw = 1'b1;
    if (rtc_cs_n && !prev_cs && in_acc) begin
      acc_q.push_back(cur);
      if (!cur.rw) mem[cur.addr] = cur.data;
      in_acc = 1'b0;
    end
    prev_cs = rtc_cs_n;
  end

  task automatic tick;
    @(negedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic int winner(input logic [2:0] m);
    if (m[0]) return 1;
    if (m[2]) return 3;
    if (m[1]) return 2;
    return 0;
  endfunction

  function automatic void build_exp(input int kind, input logic [47:0] ut);
    exp_q.delete();
    case (kind)
      1: begin
        exp_q.push_back('{1'b0, 8'h02, 8'h10});
        exp_q.push_back('{1'b0, 8'h02, 8'h00});
        exp_q.push_back('{1'b0, 8'h10, 8'h00});
      end
      2: begin
        exp_q.push_back('{1'b0, 8'hF0, 8'hF0});
        for (int i = 1; i <= N; i++) exp_q.push_back('{1'b1, 8'(32 + i), 8'h00});
      end
      3: begin
        for (int i = 0; i < N; i++) exp_q.push_back('{1'b0, 8'(33 + i), ut[8*i +: 8]});
        exp_q.push_back('{1'b0, 8'hF1, 8'hF1});
      end
      default: ;
    endcase
  endfunction

  task automatic run_cmd(input logic [2:0] mask, input logic [47:0] ut, input int drop_at,
                         input int kind, input string tag);
    int   a, k, len, own, total, fcyc;
    int   nf[3];
    logic csfin;
    build_exp(kind, ut);
    a = exp_q.size();
    if (kind == 2) for (int i = 0; i < N; i++) exp_time[8*i +: 8] = mem[33 + i];
    acc_q.delete();
    first_fall = -1;
    user_time = ut;
    {CrontUs, whileT, iniciar} = mask;
    k = cyc + 1;
    len = a * ACC + 8;  // keeps the command high well past the done pulse
    nf = '{0, 0, 0};
    fcyc = -1;
    csfin = 1'b0;
    for (int t = 1; t <= len; t++) begin
      tick;
      if (finint) nf[0]++;
      if (finwt)  nf[1]++;
      if (finct)  nf[2]++;
      if ((kind == 1 && finint) || (kind == 2 && finwt) || (kind == 3 && finct)) begin
        fcyc  = cyc;
        csfin = rtc_cs_n;
      end
      if (t == drop_at) {CrontUs, whileT, iniciar} = 3'b000;
    end
    own   = nf[kind - 1];
    total = nf[0] + nf[1] + nf[2];
    chk({tag, " own_fin_pulses"}, 64'(own), 64'd1);
    chk({tag, " other_fin_pulses"}, 64'(total - own), 64'd0);
    chk({tag, " fin_cycle"}, 64'(fcyc), 64'(k + 1 + a * ACC));
    chk({tag, " cs_high_at_fin"}, 64'(csfin), 64'd1);
    chk({tag, " first_cs_low"}, 64'(first_fall), 64'(k + 1));
    chk({tag, " n_access"}, 64'(acc_q.size()), 64'(a));
    for (int i = 0; i < a && i < acc_q.size(); i++)
      chk($sformatf("%s access%0d", tag, i),
          {acc_q[i].rw, acc_q[i].addr, acc_q[i].data, 8'(acc_q[i].cs_lo), 8'(acc_q[i].st_lo)},
          {exp_q[i].rw, exp_q[i].addr, exp_q[i].data, 8'(2 * TP + TG), 8'(2 * TP)});
    chk({tag, " rtc_time"}, 64'(rtc_time), 64'(exp_time));
    {CrontUs, whileT, iniciar} = 3'b000;
    tick;
    tick;
  endtask

  vec_t vecs[10];

  initial begin
    int nfin, nlow;
    logic [2:0] m;
    logic [47:0] ut, pre;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    vecs[0] = '{3'b001, 48'h0, 1'b0, 48'h0, 0, 1, 48'h0};
    vecs[1] = '{3'b010, 48'h0, 1'b1, 48'h160815123059, 0, 2, 48'h160815123059};
    vecs[2] = '{3'b100, 48'h161231235958, 1'b0, 48'h0, 0, 3, 48'h160815123059};
    vecs[3] = '{3'b010, 48'h0, 1'b0, 48'h0, 0, 2, 48'h161231235958};
    vecs[4] = '{3'b011, 48'h0, 1'b0, 48'h0, 0, 1, 48'h161231235958};
    vecs[5] = '{3'b010, 48'h0, 1'b0, 48'h0, 0, 2, 48'h161231235958};
    vecs[6] = '{3'b110, 48'h010203040506, 1'b0, 48'h0, 0, 3, 48'h161231235958};
    vecs[7] = '{3'b111, 48'h0, 1'b0, 48'h0, 0, 1, 48'h161231235958};
    vecs[8] = '{3'b010, 48'h0, 1'b0, 48'h0, 20, 2, 48'h010203040506};
    vecs[9] = '{3'b100, 48'h235959311299, 1'b0, 48'h0, 3, 3, 48'h010203040506};

    reset = 1'b1;
    repeat (3) tick;
    chk("reset_state",
        {rtc_cs_n, rtc_ad_n, rtc_rd_n, rtc_wr_n, rtc_ad_oe, rtc_ad_o, finint, finwt, finct, rtc_time},
        {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 3'b000, 48'h0});
    reset = 1'b0;
    tick;

    for (int v = 0; v < 10; v++) begin
      if (vecs[v].preload) for (int i = 0; i < N; i++) mem[33 + i] = vecs[v].pre[8*i +: 8];
      run_cmd(vecs[v].mask, vecs[v].ut, vecs[v].drop_at, vecs[v].kind, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d table_rtc_time", v), 64'(rtc_time), 64'(vecs[v].exp_rtc));
    end

    // Reset in the middle of a read DATA phase aborts silently
    whileT = 1'b1;
    for (int t = 0; t < 200 && rtc_rd_n; t++) tick;
    chk("abort rd_phase_reached", 64'(rtc_rd_n), 64'd0);
    tick;
    reset = 1'b1;
    tick;
    chk("abort pins_after_reset",
        {rtc_cs_n, rtc_ad_n, rtc_rd_n, rtc_wr_n, rtc_ad_oe, finint, finwt, finct, rtc_time},
        {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 48'h0});
    reset = 1'b0;
    whileT = 1'b0;
    nfin = 0;
    nlow = 0;
    for (int t = 0; t < 30; t++) begin
      tick;
      if (finint || finwt || finct) nfin++;
      if (!rtc_cs_n) nlow++;
    end
    chk("abort no_fin", 64'(nfin), 64'd0);
    chk("abort bus_quiet", 64'(nlow), 64'd0);
    acc_q.delete();
    in_acc = 1'b0;
    exp_time = '0;
    for (int i = 0; i < N; i++) mem[33 + i] = 8'(8'h41 + i);
    run_cmd(3'b010, 48'h0, 0, 2, "after_abort");

    for (int r = 0; r < 6; r++) begin
      m  = 3'($urandom_range(1, 7));
      ut = {16'($urandom), 32'($urandom)};
      pre = {16'($urandom), 32'($urandom)};
      for (int i = 0; i < N; i++) mem[33 + i] = pre[8*i +: 8];
      run_cmd(m, ut, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 80)) : 0,
              winner(m), $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
